axi_ctl_target: RTL and testbench

- AXI4-Lite slave register block at TARGET_BASE (0x0000_1000); it is the endpoint the AXI4-Lite bus-master FSMs write and read.
- Decodes an 8-word register window and accepts AW and W in either order or in the same cycle.
- Returns BRESP/RRESP and exposes the control register (word 5, offset 0x14) to downstream logic as a level and a one-cycle update strobe.

---
 rtl/axi_ctl_pkg.sv | 32 +++
 rtl/axi_ctl_target_wchan.sv | 64 ++++++
 rtl/axi_ctl_target.sv | 148 ++++++++++++++
 tb/tb_axi_ctl_target.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ctl_pkg.sv
// Shared constants for the AXI4-Lite control target and the bus-master FSMs that drive it.
package axi_ctl_pkg;

  localparam logic [31:0] TARGET_BASE = 32'h0000_1000;

  localparam logic [2:0] REG_SCRATCH0 = 3'd0;
  localparam logic [2:0] REG_SCRATCH1 = 3'd1;
  localparam logic [2:0] REG_ID       = 3'd2;
  localparam logic [2:0] REG_WR_COUNT = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_CTL      = 3'd5;
  localparam logic [2:0] REG_CTL_STATE = REG_CTL;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return merged;
  endfunction

  function automatic logic is_writable(input logic [2:0] idx);
    return (idx == REG_SCRATCH0) || (idx == REG_SCRATCH1) || (idx == REG_CTL);
  endfunction

endpackage

// File: rtl/axi_ctl_target_wchan.sv
// AW/W holding flags for the control target; emits a one-cycle commit with the merged address/data/strobe.
module axi_ctl_target_wchan #(
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic                      bvalid,
  output logic                      commit,
  output logic [AXI_ADDR_WIDTH-1:0] cmt_addr,
  output logic [31:0]               cmt_data,
  output logic [3:0]                cmt_strb
);

  logic                      aw_held;
  logic                      w_held;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               data_q;
  logic [3:0]                strb_q;
  logic                      aw_hs;
  logic                      w_hs;

  assign awready = enable && !aw_held && !bvalid;
  assign wready  = enable && !w_held && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Commit on the edge where the second half arrives, taking that half straight from the bus.
  assign commit   = (aw_held || aw_hs) && (w_held || w_hs);
  assign cmt_addr = aw_held ? addr_q : awaddr;
  assign cmt_data = w_held ? data_q : wdata;
  assign cmt_strb = w_held ? strb_q : wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi_ctl_target.sv
// AXI4-Lite register target at TARGET_BASE exposing the control register downstream.
// Define AXI_CTL_TARGET_SLVERR_EN to answer SLVERR for unmapped accesses and writes to read-only words.
module axi_ctl_target
  import axi_ctl_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE       = 32'h5445_5354
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [2:0]                  S_AXI_ARPROT,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [31:0]                 CTL_STATE,
  output logic                        CTL_STROBE,
  input  logic [31:0]                 STATUS_IN
);

  logic                      ready_en;
  logic                      commit;
  logic [AXI_ADDR_WIDTH-1:0] cmt_addr;
  logic [31:0]               cmt_data;
  logic [3:0]                cmt_strb;
  logic [31:0]               scratch0, scratch1, ctl, wr_count;
  logic [2:0]                wr_idx, rd_idx;
  logic                      wr_mapped, rd_mapped;
  logic                      wr_err, rd_err;
  logic                      ar_hs;
  logic [31:0]               rd_word;
  logic                      unused_bits;

  axi_ctl_target_wchan #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) u_wchan (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .enable   (ready_en),
    .awaddr   (S_AXI_AWADDR),
    .awvalid  (S_AXI_AWVALID),
    .awready  (S_AXI_AWREADY),
    .wdata    (S_AXI_WDATA),
    .wstrb    (S_AXI_WSTRB),
    .wvalid   (S_AXI_WVALID),
    .wready   (S_AXI_WREADY),
    .bvalid   (S_AXI_BVALID),
    .commit   (commit),
    .cmt_addr (cmt_addr),
    .cmt_data (cmt_data),
    .cmt_strb (cmt_strb)
  );

  assign wr_idx    = cmt_addr[4:2];
  assign rd_idx    = S_AXI_ARADDR[4:2];
  assign wr_mapped = cmt_addr[AXI_ADDR_WIDTH-1:5] == TARGET_BASE[AXI_ADDR_WIDTH-1:5];
  assign rd_mapped = S_AXI_ARADDR[AXI_ADDR_WIDTH-1:5] == TARGET_BASE[AXI_ADDR_WIDTH-1:5];
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;
  assign CTL_STATE = ctl;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], cmt_addr[1:0]};

`ifdef AXI_CTL_TARGET_SLVERR_EN
  assign wr_err = !wr_mapped || !is_writable(wr_idx);
  assign rd_err = !rd_mapped;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    if (rd_mapped) begin
      case (rd_idx)
        REG_SCRATCH0: rd_word = scratch0;
        REG_SCRATCH1: rd_word = scratch1;
        REG_ID:       rd_word = ID_VALUE;
        REG_WR_COUNT: rd_word = wr_count;
        REG_STATUS:   rd_word = STATUS_IN;
        REG_CTL:      rd_word = ctl;
        default:      rd_word = '0;
      endcase
    end
  end

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) ready_en <= 1'b0;
    else              ready_en <= 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      scratch0     <= '0;
      scratch1     <= '0;
      ctl          <= '0;
      wr_count     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      CTL_STROBE   <= 1'b0;
    end else if (commit) begin
      wr_count     <= wr_count + 32'd1;
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      CTL_STROBE   <= wr_mapped && (wr_idx == REG_CTL);
      if (wr_mapped && is_writable(wr_idx)) begin
        case (wr_idx)
          REG_SCRATCH0: scratch0 <= apply_wstrb(scratch0, cmt_data, cmt_strb);
          REG_SCRATCH1: scratch1 <= apply_wstrb(scratch1, cmt_data, cmt_strb);
          REG_CTL:      ctl      <= apply_wstrb(ctl, cmt_data, cmt_strb);
          default:      ;
        endcase
      end
    end else begin
      CTL_STROBE <= 1'b0;
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
    end
  end

  // Read data is captured at the AR edge, so a same-edge write is seen only by later reads.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_word;
      S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_ctl_target.sv
// Directed bench for axi_ctl_target; honours AXI_CTL_TARGET_SLVERR_EN when the design is built with it.
module tb_axi_ctl_target;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata, ctl_state, status_in;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, ctl_strobe;
  logic [1:0]  bresp, rresp;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_wr_count = 32'd0;

`ifdef AXI_CTL_TARGET_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  always #5 clk = ~clk;

  axi_ctl_target dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .CTL_STATE     (ctl_state),
    .CTL_STROBE    (ctl_strobe),
    .STATUS_IN     (status_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic strobe);
    logic a_pend, w_pend, a_hs, w_hs;
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; a_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((a_pend || w_pend) && n < 20) begin
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      tick();
      if (a_hs) begin awvalid = 1'b0; a_pend = 1'b0; end
      if (w_hs) begin wvalid = 1'b0; w_pend = 1'b0; end
      n++;
    end
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (bvalid !== 1'b1 || a_pend || w_pend) begin
      checks++; failures++;
      $display("[TB] FAIL write_timeout addr=%h bvalid=%b required 1", addr, bvalid);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx; strobe = 1'bx;
    end else begin
      resp = bresp; strobe = ctl_strobe;
      bready = 1'b1; tick(); bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; n = 0;
    while (arready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0; n = 0;
    while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (rvalid !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL read_timeout addr=%h rvalid=%b required 1", addr, rvalid);
      data = 'x; resp = 2'bxx;
    end else begin
      data = rdata; resp = rresp;
      rready = 1'b1; tick(); rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, ctl_strobe} !== 6'b0) begin
      failures++; $display("[TB] FAIL reset_handshake got=%b required 000000",
                           {awready, wready, arready, bvalid, rvalid, ctl_strobe});
    end
    checks++;
    if ({ctl_state, rdata, bresp, rresp} !== 68'h0) begin
      failures++; $display("[TB] FAIL reset_data ctl=%h rdata=%h bresp=%b rresp=%b required zeros",
                           ctl_state, rdata, bresp, rresp);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      failures++; $display("[TB] FAIL ready_before_edge got=%b required 000", {awready, wready, arready});
    end
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++; $display("[TB] FAIL ready_after_edge got=%b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d; logic [1:0] r;
    awaddr = 32'h1014; wdata = 32'h42; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++; $display("[TB] FAIL sim_bvalid bvalid=%b bresp=%b required 1/00", bvalid, bresp);
    end
    checks++;
    if (ctl_state !== 32'h42) begin
      failures++; $display("[TB] FAIL sim_ctl_state got=%h required 00000042", ctl_state);
    end
    checks++;
    if (ctl_strobe !== 1'b1) begin
      failures++; $display("[TB] FAIL sim_strobe_first got=%b required 1", ctl_strobe);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if (ctl_strobe !== 1'b0 || bvalid !== 1'b0) begin
      failures++; $display("[TB] FAIL sim_strobe_second strobe=%b bvalid=%b required 0/0", ctl_strobe, bvalid);
    end
    exp_wr_count = 32'd1;
    axi_read(32'h100C, d, r);
    checks++;
    if (d !== exp_wr_count) begin
      failures++; $display("[TB] FAIL sim_wr_count got=%h required %h", d, exp_wr_count);
    end
  endtask

  task automatic test_w_first();
    logic [31:0] d; logic [1:0] r; logic ok;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL wfirst_no_commit bvalid=%b wready=%b required 0/0", bvalid, wready);
    end
    awaddr = 32'h1000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++; $display("[TB] FAIL wfirst_commit bvalid=%b bresp=%b required 1/00", bvalid, bresp);
    end
    ok = 1'b1;
    repeat (5) begin
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL bvalid_hold awready=%b bvalid=%b required 0/1", awready, bvalid);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++; $display("[TB] FAIL bvalid_release bvalid=%b awready=%b required 0/1", bvalid, awready);
    end
    exp_wr_count++;
    axi_read(32'h1000, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      failures++; $display("[TB] FAIL wfirst_readback got=%h/%b required deadbeef/00", d, r);
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; logic s;
    axi_write(32'h1004, 32'h11223344, 4'hF, r, s);
    axi_write(32'h1004, 32'hAABBCCDD, 4'h6, r, s);
    exp_wr_count += 2;
    checks++;
    if (r !== 2'b00 || s !== 1'b0) begin
      failures++; $display("[TB] FAIL strb_resp resp=%b strobe=%b required 00/0", r, s);
    end
    axi_read(32'h1004, d, r);
    checks++;
    if (d !== 32'h11BBCC44) begin
      failures++; $display("[TB] FAIL strb_merge got=%h required 11bbcc44", d);
    end
    axi_write(32'h1014, 32'hFFFFFFFF, 4'h0, r, s);
    exp_wr_count++;
    checks++;
    if (s !== 1'b1 || ctl_state !== 32'h42) begin
      failures++; $display("[TB] FAIL ctl_strb0 strobe=%b ctl=%h required 1/00000042", s, ctl_state);
    end
    axi_write(32'h1014, 32'h0000A500, 4'h2, r, s);
    exp_wr_count++;
    checks++;
    if (ctl_state !== 32'h0000A542) begin
      failures++; $display("[TB] FAIL ctl_byte1 got=%h required 0000a542", ctl_state);
    end
  endtask

  task automatic test_read();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_read(32'h1008, d, r);
    checks++;
    if (d !== 32'h54455354 || r !== 2'b00) begin
      failures++; $display("[TB] FAIL read_id got=%h/%b required 54455354/00", d, r);
    end
    status_in = 32'h5;
    axi_read(32'h1010, d, r);
    checks++;
    if (d !== 32'h5) begin
      failures++; $display("[TB] FAIL read_status got=%h required 00000005", d);
    end
    axi_read(32'h101B, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      failures++; $display("[TB] FAIL read_reserved got=%h/%b required 0/00", d, r);
    end
    axi_read(32'h100C, d, r);
    checks++;
    if (d !== exp_wr_count) begin
      failures++; $display("[TB] FAIL read_wr_count got=%h required %h", d, exp_wr_count);
    end
    araddr = 32'h1010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; status_in = 32'h99;
    ok = 1'b1;
    repeat (4) begin
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'h5) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL rvalid_hold rdata=%h arready=%b required 00000005/0", rdata, arready);
    end
    rready = 1'b1; tick(); rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("[TB] FAIL rvalid_release rvalid=%b arready=%b required 0/1", rvalid, arready);
    end
    axi_read(32'h1010, d, r);
    checks++;
    if (d !== 32'h99) begin
      failures++; $display("[TB] FAIL status_live got=%h required 00000099", d);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; logic s;
    axi_write(32'h2000, 32'h12345678, 4'hF, r, s);
    exp_wr_count++;
    checks++;
    if (r !== EXP_ERR) begin
      failures++; $display("[TB] FAIL unmapped_bresp got=%b required %b", r, EXP_ERR);
    end
    axi_read(32'h1000, d, r);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL unmapped_no_write got=%h required deadbeef", d);
    end
    axi_write(32'h1008, 32'h0, 4'hF, r, s);
    exp_wr_count++;
    checks++;
    if (r !== EXP_ERR) begin
      failures++; $display("[TB] FAIL ro_bresp got=%b required %b", r, EXP_ERR);
    end
    axi_read(32'h1008, d, r);
    checks++;
    if (d !== 32'h54455354 || r !== 2'b00) begin
      failures++; $display("[TB] FAIL ro_unchanged got=%h/%b required 54455354/00", d, r);
    end
    axi_read(32'h2000, d, r);
    checks++;
    if (d !== 32'h0 || r !== EXP_ERR) begin
      failures++; $display("[TB] FAIL unmapped_read got=%h/%b required 0/%b", d, r, EXP_ERR);
    end
    axi_read(32'h100C, d, r);
    checks++;
    if (d !== exp_wr_count) begin
      failures++; $display("[TB] FAIL unmapped_wr_count got=%h required %h", d, exp_wr_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; logic ok;
    awaddr = 32'h1000; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h1004; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_setup bvalid=%b rvalid=%b required 1/1", bvalid, rvalid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_async_clear bvalid=%b rvalid=%b required 0/0", bvalid, rvalid);
    end
    tick(); rst = 1'b0; tick();
    exp_wr_count = 32'd0;
    checks++;
    if (ctl_state !== 32'h0) begin
      failures++; $display("[TB] FAIL mid_ctl_state got=%h required 0", ctl_state);
    end
    axi_read(32'h100C, d, r);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("[TB] FAIL mid_wr_count got=%h required 0", d);
    end
    // A lone W latched before reset must not pair with a later AW.
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    #2 rst = 1'b1;
    tick(); rst = 1'b0; tick();
    awaddr = 32'h1004; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      if (bvalid !== 1'b0) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL mid_partial_discard bvalid=%b required 0", bvalid);
    end
    wdata = 32'h77; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_complete bvalid=%b required 1", bvalid);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    axi_read(32'h1004, d, r);
    checks++;
    if (d !== 32'h77) begin
      failures++; $display("[TB] FAIL mid_readback got=%h required 00000077", d);
    end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; awprot = 3'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; arprot = 3'b0; rready = 1'b0; status_in = '0;
    test_reset();
    test_simultaneous();
    test_w_first();
    test_wstrb();
    test_read();
    test_unmapped();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
